// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg -- shared definitions for the PLL phase-shift controller.
// Holds the controller state encoding, the PLL output channel codes and a
// saturating increment helper for the lock-loss counter.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_STEP_LO   = 3'd4,
    ST_STEP_GAP  = 3'd5
  } state_t;

  // Output channel codes as presented on phasesel.
  localparam logic [1:0] CH_CLKOP  = 2'd0;
  localparam logic [1:0] CH_CLKOS  = 2'd1;
  localparam logic [1:0] CH_CLKOS2 = 2'd2;
  localparam logic [1:0] CH_CLKOS3 = 2'd3;

  // phasesel/phasedir must be stable this many cycles before the first step.
  localparam int SETUP_CYCLES = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/pll_phase_ctrl_lock_filter.sv
// lock_filter -- brings the asynchronous PLL LOCK into the clk domain and
// qualifies it.
//   clk, reset     : clock, asynchronous active-high reset
//   i_lock_async   : raw PLL LOCK
//   i_clr          : holds the consecutive-high counter at zero
//   o_synced       : LOCK after the two-flop synchroniser
//   o_qualified    : high once o_synced has been high LOCK_FILTER cycles in a row
module lock_filter
  import pll_ctrl_pkg::*;
#(
  parameter int LOCK_FILTER = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_lock_async,
  input  logic i_clr,
  output logic o_synced,
  output logic o_qualified
);

  localparam int CW = $clog2(LOCK_FILTER + 1);
  localparam logic [CW-1:0] FILT_MAX = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] FILT_THR = CW'(LOCK_FILTER - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_qual;

  // Two-flop synchroniser for the asynchronous LOCK input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_lock_async;
      r_sync2 <= r_sync1;
    end
  end

  // Consecutive-high counter; any low cycle or clear restarts it, it saturates at the target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= {CW{1'b0}};
      r_qual <= 1'b0;
    end else if (i_clr || !r_sync2) begin
      r_cnt  <= {CW{1'b0}};
      r_qual <= 1'b0;
    end else if (r_cnt >= FILT_THR) begin
      r_cnt  <= FILT_MAX;
      r_qual <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1'b1);
      r_qual <= 1'b0;
    end
  end

  assign o_synced    = r_sync2;
  assign o_qualified = r_qual;

endmodule

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl -- PLL reset/lock sequencer and dynamic phase-shift engine.
//   clk, reset                          : clock, asynchronous active-high reset
//   pll_lock                            : raw PLL LOCK (asynchronous)
//   req_valid/req_sel/req_dir/req_count : phase-shift command, taken when req_ready
//   req_ready, done                     : accept strobe window, completion pulse
//   pll_rst                             : PLL RST drive
//   phasesel/phasedir/phasestep/phaseloadreg : PLL dynamic phase pins
//   locked, relock_cnt                  : qualified lock, saturating lock-loss count
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES  = 16,
  parameter int LOCK_FILTER = 255,
  parameter int STEP_LOW    = 4,
  parameter int STEP_GAP    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [3:0] req_count,
  output logic       req_ready,
  output logic       done,
  output logic       pll_rst,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic       locked,
  output logic [7:0] relock_cnt
);

  localparam int HW   = $clog2(RST_CYCLES + 1);
  localparam int TMAX = (STEP_LOW > STEP_GAP)
                        ? ((STEP_LOW > SETUP_CYCLES) ? STEP_LOW : SETUP_CYCLES)
                        : ((STEP_GAP > SETUP_CYCLES) ? STEP_GAP : SETUP_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LAST   = TW'(STEP_LOW - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(STEP_GAP - 1);

  state_t        r_state;
  logic [HW-1:0] r_hold;
  logic [TW-1:0] r_tmr;
  logic [3:0]    r_steps;
  logic          r_pll_rst;
  logic          r_ready;
  logic          r_done;
  logic          r_locked;
  logic          r_phasestep;
  logic          r_phaseloadreg;
  logic [1:0]    r_phasesel;
  logic          r_phasedir;
  logic [7:0]    r_relock_cnt;

  logic w_sync;
  logic w_qual;
  logic w_filt_clr;
  logic w_abort;

  // The filter only accumulates while waiting for lock, so it starts fresh every attempt.
  assign w_filt_clr = (r_state != ST_WAIT_LOCK);

  // Lock loss is fatal in every operational state; WAIT_LOCK only restarts the filter.
  assign w_abort = !w_sync && ((r_state == ST_IDLE)    || (r_state == ST_SETUP) ||
                               (r_state == ST_STEP_LO) || (r_state == ST_STEP_GAP));

  lock_filter #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .clk          (clk),
    .reset        (reset),
    .i_lock_async (pll_lock),
    .i_clr        (w_filt_clr),
    .o_synced     (w_sync),
    .o_qualified  (w_qual)
  );

  // Main sequencer: reset hold, lock wait, command accept and step generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_RESET;
      r_hold         <= {HW{1'b0}};
      r_tmr          <= {TW{1'b0}};
      r_steps        <= 4'd0;
      r_pll_rst      <= 1'b1;
      r_ready        <= 1'b0;
      r_done         <= 1'b0;
      r_locked       <= 1'b0;
      r_phasestep    <= 1'b1;
      r_phaseloadreg <= 1'b1;
      r_phasesel     <= CH_CLKOP;
      r_phasedir     <= 1'b0;
      r_relock_cnt   <= 8'd0;
    end else begin
      r_done         <= 1'b0;
      r_phaseloadreg <= 1'b1;
      if (w_abort) begin
        r_state      <= ST_RESET;
        r_hold       <= {HW{1'b0}};
        r_pll_rst    <= 1'b1;
        r_ready      <= 1'b0;
        r_locked     <= 1'b0;
        r_phasestep  <= 1'b1;
        r_relock_cnt <= sat_inc8(r_relock_cnt);
      end else begin
        case (r_state)
          ST_RESET: begin
            r_pll_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_locked    <= 1'b0;
            r_phasestep <= 1'b1;
            if (r_hold == HOLD_LAST) begin
              r_hold    <= {HW{1'b0}};
              r_pll_rst <= 1'b0;
              r_state   <= ST_WAIT_LOCK;
            end else begin
              r_hold <= r_hold + HW'(1'b1);
            end
          end
          ST_WAIT_LOCK: begin
            if (w_qual) begin
              r_state  <= ST_IDLE;
              r_locked <= 1'b1;
              r_ready  <= 1'b1;
            end else begin
              r_state <= ST_WAIT_LOCK;
            end
          end
          ST_IDLE: begin
            if (req_valid) begin
              r_phasesel <= req_sel;
              r_phasedir <= req_dir;
              r_steps    <= req_count;
              if (req_count == 4'd0) begin
                // Nothing to step: complete immediately and stay ready.
                r_done <= 1'b1;
              end else begin
                r_state <= ST_SETUP;
                r_ready <= 1'b0;
                r_tmr   <= SETUP_LAST;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_SETUP: begin
            if (r_tmr == {TW{1'b0}}) begin
              r_state     <= ST_STEP_LO;
              r_phasestep <= 1'b0;
              r_tmr       <= LOW_LAST;
            end else begin
              r_tmr <= r_tmr - TW'(1'b1);
            end
          end
          ST_STEP_LO: begin
            if (r_tmr == {TW{1'b0}}) begin
              r_state     <= ST_STEP_GAP;
              r_phasestep <= 1'b1;
              r_tmr       <= GAP_LAST;
            end else begin
              r_tmr <= r_tmr - TW'(1'b1);
            end
          end
          ST_STEP_GAP: begin
            if (r_tmr != {TW{1'b0}}) begin
              r_tmr <= r_tmr - TW'(1'b1);
            end else if (r_steps == 4'd1) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end else begin
              r_steps     <= r_steps - 4'd1;
              r_state     <= ST_STEP_LO;
              r_phasestep <= 1'b0;
              r_tmr       <= LOW_LAST;
            end
          end
          default: begin
            r_state     <= ST_RESET;
            r_hold      <= {HW{1'b0}};
            r_pll_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_locked    <= 1'b0;
            r_phasestep <= 1'b1;
          end
        endcase
      end
    end
  end

  assign req_ready    = r_ready;
  assign done         = r_done;
  assign pll_rst      = r_pll_rst;
  assign phasesel     = r_phasesel;
  assign phasedir     = r_phasedir;
  assign phasestep    = r_phasestep;
  assign phaseloadreg = r_phaseloadreg;
  assign locked       = r_locked;
  assign relock_cnt   = r_relock_cnt;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl -- directed self-checking bench for pll_phase_ctrl with
// RST_CYCLES=4, LOCK_FILTER=8, STEP_LOW=2, STEP_GAP=3.
// Outputs are sampled 1 time unit after each rising edge; the sample taken
// right after acceptance edge T shows cycle T+1.
module tb_pll_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [3:0] req_count;
  logic       req_ready;
  logic       done;
  logic       pll_rst;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic       locked;
  logic [7:0] relock_cnt;

  int checks   = 0;
  int failures = 0;

  pll_phase_ctrl #(
    .RST_CYCLES  (4),
    .LOCK_FILTER (8),
    .STEP_LOW    (2),
    .STEP_GAP    (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_count    (req_count),
    .req_ready    (req_ready),
    .done         (done),
    .pll_rst      (pll_rst),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .locked       (locked),
    .relock_cnt   (relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int n;
    int m;
    reset = 1'b1; pll_lock = 1'b1; req_valid = 1'b0;
    req_sel = 2'd0; req_dir = 1'b0; req_count = 4'd0;
    repeat (3) tick;
    checks++;
    if ({pll_rst, locked, req_ready, done, phasestep, phaseloadreg, phasesel, phasedir, relock_cnt}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_outputs got rst=%0b lk=%0b rdy=%0b dn=%0b ps=%0b plr=%0b sel=%0d dir=%0b rc=%0d exp 1 0 0 0 1 1 0 0 0",
               pll_rst, locked, req_ready, done, phasestep, phaseloadreg, phasesel, phasedir, relock_cnt);
    end
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (pll_rst !== 1'b1) break;
      n++;
      tick;
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL rst_hold_len got=%0d exp=4", n);
    end
    m = 0;
    while (locked !== 1'b1 && m < 20) begin
      tick;
      m++;
    end
    checks++;
    if (locked !== 1'b1 || req_ready !== 1'b1 || m < 8 || m > 11) begin
      failures++;
      $display("FAIL lock_time got cycles=%0d locked=%0b ready=%0b exp cycles 8..11 locked=1 ready=1",
               m, locked, req_ready);
    end
  endtask

  task automatic test_step;
    logic exp_low, exp_done, exp_ready;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL step_pre_ready got=%0b exp=1", req_ready);
    end
    req_sel = 2'd2; req_dir = 1'b1; req_count = 4'd3; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    // SETUP occupies s=0,1; then three 5-cycle periods, first 2 cycles low; done at s=17 (T+18).
    for (int s = 0; s < 21; s++) begin
      exp_low   = (s >= 2) && (s < 17) && (((s - 2) % 5) < 2);
      exp_done  = (s == 17);
      exp_ready = (s >= 17);
      checks++;
      if ({phasestep, phaseloadreg | exp_low, done, req_ready, phasesel, phasedir}
          !== {~exp_low, 1'b1, exp_done, exp_ready, 2'd2, 1'b1}) begin
        failures++;
        $display("FAIL step_seq s=%0d got ps=%0b plr=%0b dn=%0b rdy=%0b sel=%0d dir=%0b exp ps=%0b dn=%0b rdy=%0b sel=2 dir=1",
                 s, phasestep, phaseloadreg, done, req_ready, phasesel, phasedir, ~exp_low, exp_done, exp_ready);
      end
      tick;
    end
  endtask

  task automatic test_zero;
    req_sel = 2'd1; req_dir = 1'b0; req_count = 4'd0; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    for (int s = 0; s < 6; s++) begin
      checks++;
      if ({done, req_ready, phasestep} !== {(s == 0), 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL zero_count s=%0d got dn=%0b rdy=%0b ps=%0b exp dn=%0b rdy=1 ps=1",
                 s, done, req_ready, phasestep, (s == 0));
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int m;
    req_sel = 2'd2; req_dir = 1'b1; req_count = 4'd1; req_valid = 1'b1;
    tick;
    // Keep requesting with a different channel while the first command runs.
    req_sel = 2'd3; req_dir = 1'b0;
    for (int s = 0; s < 8; s++) begin
      checks++;
      if ({done, req_ready, phasesel, phasedir} !== {(s == 7), (s == 7), 2'd2, 1'b1}) begin
        failures++;
        $display("FAIL b2b_busy s=%0d got dn=%0b rdy=%0b sel=%0d dir=%0b exp dn=%0b rdy=%0b sel=2 dir=1",
                 s, done, req_ready, phasesel, phasedir, (s == 7), (s == 7));
      end
      tick;
    end
    req_valid = 1'b0;
    checks++;
    if ({phasesel, phasedir, req_ready, done} !== {2'd3, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second_accept got sel=%0d dir=%0b rdy=%0b dn=%0b exp sel=3 dir=0 rdy=0 dn=0",
               phasesel, phasedir, req_ready, done);
    end
    m = 0;
    while (done !== 1'b1 && m < 20) begin
      tick;
      m++;
    end
    checks++;
    if (m != 7) begin
      failures++;
      $display("FAIL b2b_second_done got cycles=%0d exp=7", m);
    end
    tick;
  endtask

  task automatic test_lock_loss;
    int  m;
    int  n;
    logic seen_done;
    seen_done = 1'b0;
    req_sel = 2'd1; req_dir = 1'b0; req_count = 4'd5; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (7) begin
      tick;
      if (done === 1'b1) seen_done = 1'b1;
    end
    // s=7: first cycle of the second STEP_LO.
    checks++;
    if (phasestep !== 1'b0) begin
      failures++;
      $display("FAIL loss_in_step_lo got ps=%0b exp=0", phasestep);
    end
    pll_lock = 1'b0;
    m = 0;
    while (pll_rst !== 1'b1 && m < 10) begin
      tick;
      m++;
      if (done === 1'b1) seen_done = 1'b1;
    end
    // Two synchroniser flops, then abort on the following edge.
    checks++;
    if (m != 3) begin
      failures++;
      $display("FAIL loss_abort_latency got=%0d exp=3", m);
    end
    checks++;
    if ({phasestep, locked, req_ready, done, relock_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL loss_abort_state got ps=%0b lk=%0b rdy=%0b dn=%0b rc=%0d exp ps=1 lk=0 rdy=0 dn=0 rc=1",
               phasestep, locked, req_ready, done, relock_cnt);
    end
    pll_lock = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (pll_rst !== 1'b1) break;
      if (done === 1'b1) seen_done = 1'b1;
      n++;
      tick;
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL loss_rst_hold got=%0d exp=4", n);
    end
    m = 0;
    while (locked !== 1'b1 && m < 20) begin
      tick;
      m++;
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if ({locked, req_ready, relock_cnt, seen_done} !== {1'b1, 1'b1, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL loss_relock got lk=%0b rdy=%0b rc=%0d done_seen=%0b exp lk=1 rdy=1 rc=1 done_seen=0",
               locked, req_ready, relock_cnt, seen_done);
    end
  endtask

  task automatic test_filter_restart;
    int e;
    reset = 1'b1; pll_lock = 1'b1; req_valid = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    repeat (4) tick;
    checks++;
    if (pll_rst !== 1'b0) begin
      failures++;
      $display("FAIL filt_rst_released got=%0b exp=0", pll_rst);
    end
    repeat (3) tick;
    pll_lock = 1'b0;
    tick;
    pll_lock = 1'b1;
    // The low reaches the filter at edge 10; 8 fresh highs end at edge 18, lock shows at 19.
    e = 8;
    while (locked !== 1'b1 && e < 40) begin
      tick;
      e++;
    end
    checks++;
    if (e != 19) begin
      failures++;
      $display("FAIL filt_restart_lock_edge got=%0d exp=19", e);
    end
    checks++;
    if (relock_cnt !== 8'd0) begin
      failures++;
      $display("FAIL filt_relock_cnt got=%0d exp=0", relock_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_step;
    test_zero;
    test_back_to_back;
    test_lock_loss;
    test_filter_restart;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_phase_ctrl.md
PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: PLL reset hold length in clk cycles (min 1).
REQ-002 SHALL have parameter LOCK_FILTER, default 255: consecutive synced-lock-high cycles needed to qualify lock (min 1).
REQ-003 SHALL have parameter STEP_LOW, default 4: phasestep low width per step in clk cycles (min 1).
REQ-004 SHALL have parameter STEP_GAP, default 4: phasestep high gap after each step in clk cycles (min 1).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port pll_lock, input, 1: raw PLL LOCK, asynchronous to clk.
REQ-008 SHALL have port req_valid, input, 1: phase-shift command valid.
REQ-009 SHALL have port req_sel, input, 2: output channel (0 CLKOP, 1 CLKOS, 2 CLKOS2, 3 CLKOS3).
REQ-010 SHALL have port req_dir, input, 1: shift direction (0 lag, 1 lead).
REQ-011 SHALL have port req_count, input, 4: number of steps, 0..15.
REQ-012 SHALL have port req_ready, output, 1: command accepted when req_valid and req_ready are both high on a clk edge.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on command completion.
REQ-014 SHALL have port pll_rst, output, 1: PLL RST drive, active-high.
REQ-015 SHALL have ports phasesel (2), phasedir (1), phasestep (1), phaseloadreg (1), all outputs driving the matching PLL pins.
REQ-016 SHALL have port locked, output, 1: qualified lock.
REQ-017 SHALL have port relock_cnt, output, 8: saturating count of lock losses.

Function
REQ-018 SHALL synchronise pll_lock through two flops before any use.
REQ-019 SHALL implement states RESET, WAIT_LOCK, IDLE, SETUP, STEP_LO, STEP_GAP.
REQ-020 In RESET, SHALL hold pll_rst=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK with pll_rst=0.
REQ-021 In WAIT_LOCK, SHALL enter IDLE and set locked=1 after synced lock has been high for LOCK_FILTER consecutive cycles; any low cycle restarts the filter count.
REQ-022 SHALL drive req_ready=1 only in IDLE.
REQ-023 On acceptance at edge T, SHALL latch sel/dir/count; if count=0, SHALL return to IDLE with done=1 in cycle T+1 and no phasestep pulse.
REQ-024 For count N>0, SHALL drive phasesel/phasedir with latched values from T+1, hold them stable in SETUP for 2 cycles, then perform N iterations of STEP_LO (phasestep=0 for STEP_LOW cycles) followed by STEP_GAP (phasestep=1 for STEP_GAP cycles).
REQ-025 SHALL assert done in cycle T+3+N*(STEP_LOW+STEP_GAP), in IDLE, with req_ready=1 in that same cycle.
REQ-026 SHALL keep phasesel/phasedir at their last values in IDLE, ignore req_* outside IDLE, and drive phasestep=1 and phaseloadreg=1 at all times other than STEP_LO.
REQ-027 If synced lock is low for any cycle in IDLE, SETUP, STEP_LO or STEP_GAP, SHALL on the next edge abort the command without done, set locked=0 and phasestep=1, increment relock_cnt (saturating at 255), and enter RESET.
REQ-028 Loss of lock in WAIT_LOCK SHALL only restart the filter and SHALL NOT increment relock_cnt.

Reset
REQ-029 While reset is high, SHALL force state RESET with the hold counter cleared, pll_rst=1, locked=0, req_ready=0, done=0, phasestep=1, phaseloadreg=1, phasesel=0, phasedir=0, relock_cnt=0, and sync flops=0.
REQ-030 After reset deasserts, SHALL run the full RST_CYCLES hold regardless of pll_lock.

Structure
REQ-031 SHALL place the state encoding and channel constants (CH_CLKOP..CH_CLKOS3) in shared package pll_ctrl_pkg.
REQ-032 SHALL implement the two-flop synchroniser and consecutive-high filter as sub-module lock_filter, outputting the qualified level and the raw synced level.

Verification (bench parameters RST_CYCLES=4, LOCK_FILTER=8, STEP_LOW=2, STEP_GAP=3)
REQ-033 Release reset with pll_lock=1 -> pll_rst high for exactly 4 cycles; locked=1 and req_ready=1 at most 8+2+1 cycles after pll_rst falls.
REQ-034 Accept sel=2, dir=1, count=3 at T -> phasesel=2 and phasedir=1 from T+1; three phasestep low pulses of 2 cycles each, 3-cycle gaps; done at T+18.
REQ-035 Accept count=0 -> done at T+1, phasestep never low.
REQ-036 Drop pll_lock during the second STEP_LO of a count=5 command -> no done, phasestep=1, pll_rst high for 4 cycles, relock_cnt=1, and re-qualified lock afterwards.
REQ-037 Pulse pll_lock low 1 cycle mid-WAIT_LOCK -> filter restarts, full 8 high cycles required, relock_cnt unchanged.
REQ-038 Hold req_valid high during a busy command with changed sel -> second command accepted only in the done cycle; the busy command's phasesel is unchanged.
